// File: rtl/scs_pkg.sv
// Shared definitions for the checksum/frame transmit slice: RAM geometry,
// trailer size and the frame_tx state encoding.
package scs_pkg;

  localparam int RAM_WIDTH     = 8;
  localparam int RAM_ADDR_BITS = 11;
  localparam int TRAILER_BYTES = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR_HI,
    S_HDR_LO,
    S_RD_WAIT,
    S_RD_LOAD,
    S_SEND,
    S_DONE
  } tx_state_t;

endpackage

// File: rtl/frame_tx.sv
// Streams a finished frame from the shared byte RAM: 2-byte big-endian length
// header, payload, then the checksum trailer, over a valid/ready byte stream.
module frame_tx
  import scs_pkg::*;
#(
  parameter int RAM_WIDTH     = scs_pkg::RAM_WIDTH,
  parameter int RAM_ADDR_BITS = scs_pkg::RAM_ADDR_BITS,
  parameter int TRAILER_BYTES = scs_pkg::TRAILER_BYTES
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic [15:0]              payload_len,
  output logic [RAM_ADDR_BITS-1:0] address,
  input  logic [RAM_WIDTH-1:0]     mem_output,
  output logic                     busy,
  output logic [RAM_WIDTH-1:0]     tx_data,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  output logic                     done,
  output logic                     len_error
);

  tx_state_t   r_state;
  logic [15:0] r_len;

  logic [16:0] w_total;
  logic        w_fits;
  logic [16:0] w_last;
  logic        w_is_last;
  logic        w_xfer;

  // 17-bit arithmetic so a 0xFFFF length cannot wrap past the RAM size check.
  assign w_total   = {1'b0, payload_len} + 17'(TRAILER_BYTES);
  assign w_fits    = (w_total <= (17'd1 << RAM_ADDR_BITS));
  assign w_last    = {1'b0, r_len} + 17'(TRAILER_BYTES) - 17'd1;
  assign w_is_last = ({{(17-RAM_ADDR_BITS){1'b0}}, address} == w_last);
  assign w_xfer    = tx_valid & tx_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_len     <= '0;
      address   <= '0;
      busy      <= 1'b0;
      tx_data   <= '0;
      tx_valid  <= 1'b0;
      done      <= 1'b0;
      len_error <= 1'b0;
    end else begin
      done      <= 1'b0;
      len_error <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (w_fits) begin
              r_len    <= payload_len;
              address  <= '0;
              tx_data  <= RAM_WIDTH'(payload_len[15:8]);
              tx_valid <= 1'b1;
              busy     <= 1'b1;
              r_state  <= S_HDR_HI;
            end else begin
              len_error <= 1'b1;
            end
          end
        end
        S_HDR_HI: begin
          if (w_xfer) begin
            tx_data <= RAM_WIDTH'(r_len[7:0]);
            r_state <= S_HDR_LO;
          end
        end
        S_HDR_LO: begin
          if (w_xfer) begin
            tx_valid <= 1'b0;
            r_state  <= S_RD_WAIT;
          end
        end
        // Registered RAM samples the address during this cycle.
        S_RD_WAIT: r_state <= S_RD_LOAD;
        S_RD_LOAD: begin
          tx_data  <= mem_output;
          tx_valid <= 1'b1;
          r_state  <= S_SEND;
        end
        S_SEND: begin
          if (w_xfer) begin
            tx_valid <= 1'b0;
            if (w_is_last) begin
              done    <= 1'b1;
              busy    <= 1'b0;
              r_state <= S_DONE;
            end else begin
              address <= address + 1'b1;
              r_state <= S_RD_WAIT;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_tx.sv
// Directed bench for frame_tx with a registered-RAM model and a stream monitor.
module tb_frame_tx;
  import scs_pkg::*;

  logic        clock = 1'b0;
  logic        reset, start, tx_ready;
  logic [15:0] payload_len;
  logic [10:0] address;
  logic [7:0]  mem_output = 8'h00;
  logic [7:0]  tx_data;
  logic        busy, tx_valid, done, len_error;

  int checks = 0;
  int failures = 0;

  frame_tx dut (
    .clock(clock), .reset(reset), .start(start), .payload_len(payload_len),
    .address(address), .mem_output(mem_output), .busy(busy), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .done(done), .len_error(len_error)
  );

  always #5 clock = ~clock;

  logic [7:0] ram [0:2047];
  always @(posedge clock) mem_output <= ram[address];

  // Stream monitor: everything is sampled on the falling edge.
  logic [7:0] q[$];
  int   cyc = 0;
  int   done_cnt = 0, gap_err = 0, stab_err = 0, valid_seen = 0;
  int   low_run = 0, cur_max = 0, last_max = -1;
  int   last_xfer_cyc = 0, done_cyc = 0;
  logic prev_v = 1'b0, prev_r = 1'b0, prev_busy = 1'b0;
  logic [7:0] prev_d = 8'h00;

  always @(posedge clock) cyc++;

  always @(negedge clock) begin
    if (tx_valid && tx_ready) begin
      q.push_back(tx_data);
      last_xfer_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (tx_valid) valid_seen++;
    if (busy && int'(address) > cur_max) cur_max = int'(address);
    if (prev_busy && !busy) begin
      last_max = cur_max;
      cur_max  = 0;
    end
    prev_busy = busy;
    if (prev_v && !prev_r && !(tx_valid && tx_data == prev_d)) stab_err++;
    prev_v = tx_valid && !reset;
    prev_r = tx_ready;
    prev_d = tx_data;
    if (busy && !tx_valid) low_run++;
    else begin
      if (busy && tx_valid && low_run != 0 && low_run != 2) gap_err++;
      low_run = 0;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_start(input logic [15:0] len);
    payload_len = len;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    tick();
  endtask

  // Expected frame: header, then RAM[0..len+1]; -1 means the window matches.
  function automatic int frame_diff(int base, int len);
    int n = len + 4;
    logic [15:0] l = 16'(len);
    logic [7:0] e;
    if (q.size() - base < n) return -2;
    for (int k = 0; k < n; k++) begin
      if (k == 0) e = l[15:8];
      else if (k == 1) e = l[7:0];
      else e = ram[k-2];
      if (q[base+k] !== e) return k;
    end
    return -1;
  endfunction

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; tx_ready = 1'b0; payload_len = 16'h0;
    tick(); tick();
    checks++;
    if ({busy, tx_valid, done, len_error, tx_data, address} !== 23'h0) begin
      failures++;
      $display("FAIL reset_outputs: got %h want 0", {busy, tx_valid, done, len_error, tx_data, address});
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int base, d0, g0, r;
    bit ok;
    ram[0] = 8'h11; ram[1] = 8'h22; ram[2] = 8'h33; ram[3] = 8'hAB; ram[4] = 8'hCD;
    tx_ready = 1'b1;
    base = q.size(); d0 = done_cnt; g0 = gap_err;
    do_start(16'd3);
    wait_done(100, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL basic_done_timeout: got no done want done"); end
    r = frame_diff(base, 3);
    checks++;
    if (r != -1) begin failures++; $display("FAIL basic_frame: bad index %0d want -1", r); end
    checks++;
    if (done_cnt - d0 != 1) begin failures++; $display("FAIL basic_done_count: got %0d want 1", done_cnt - d0); end
    checks++;
    if (done_cyc != last_xfer_cyc + 1) begin
      failures++; $display("FAIL basic_done_latency: got %0d want 1", done_cyc - last_xfer_cyc);
    end
    checks++;
    if (gap_err != g0) begin failures++; $display("FAIL basic_gaps: got %0d bad gaps want 0", gap_err - g0); end
  endtask

  task automatic test_len0();
    int base, r;
    bit ok;
    ram[0] = 8'h5A; ram[1] = 8'hA5;
    tx_ready = 1'b1;
    base = q.size();
    do_start(16'd0);
    wait_done(100, ok);
    r = frame_diff(base, 0);
    checks++;
    if (!ok || r != -1 || q.size() - base != 4) begin
      failures++; $display("FAIL len0_frame: ok=%0d idx=%0d bytes=%0d want 1,-1,4", ok, r, q.size() - base);
    end
    checks++;
    if (last_max != 1) begin failures++; $display("FAIL len0_max_addr: got %0d want 1", last_max); end
  endtask

  task automatic test_stall();
    int base, s0, r;
    bit hold_ok = 1'b1;
    bit ok = 1'b0;
    ram[0] = 8'h01; ram[1] = 8'h02; ram[2] = 8'hC3; ram[3] = 8'h3C;
    tx_ready = 1'b0;
    base = q.size(); s0 = stab_err;
    do_start(16'd2);
    for (int i = 0; i < 5; i++) begin
      if (!(tx_valid === 1'b1 && tx_data === 8'h00)) hold_ok = 1'b0;
      tick();
    end
    checks++;
    if (!hold_ok) begin failures++; $display("FAIL stall_header_hold: got unstable want 00 held"); end
    for (int i = 0; i < 200; i++) begin
      tx_ready = ~tx_ready;
      tick();
      if (done) begin ok = 1'b1; break; end
    end
    tx_ready = 1'b1;
    tick();
    r = frame_diff(base, 2);
    checks++;
    if (!ok || r != -1) begin failures++; $display("FAIL stall_frame: ok=%0d idx=%0d want 1,-1", ok, r); end
    checks++;
    if (stab_err != s0) begin failures++; $display("FAIL stall_stability: got %0d violations want 0", stab_err - s0); end
  endtask

  task automatic test_oversize();
    int base, v0, r;
    bit ok;
    tx_ready = 1'b1;
    base = q.size();
    do_start(16'd2047);
    checks++;
    if (len_error !== 1'b1 || busy !== 1'b0 || tx_valid !== 1'b0) begin
      failures++; $display("FAIL oversize_reject: got err=%b busy=%b vld=%b want 1,0,0", len_error, busy, tx_valid);
    end
    v0 = valid_seen;
    tick();
    checks++;
    if (len_error !== 1'b0) begin failures++; $display("FAIL oversize_pulse: got %b want 0", len_error); end
    repeat (10) tick();
    checks++;
    if (valid_seen != v0 || busy !== 1'b0 || q.size() != base) begin
      failures++; $display("FAIL oversize_quiet: got %0d valid cycles busy=%b want 0,0", valid_seen - v0, busy);
    end
    for (int i = 0; i < 2048; i++) ram[i] = 8'((i * 7 + 3) ^ (i >> 8));
    base = q.size();
    do_start(16'd2046);
    wait_done(20000, ok);
    r = frame_diff(base, 2046);
    checks++;
    if (!ok || r != -1) begin failures++; $display("FAIL max_frame: ok=%0d idx=%0d want 1,-1", ok, r); end
    checks++;
    if (last_max != 2047) begin failures++; $display("FAIL max_frame_addr: got %0d want 2047", last_max); end
  endtask

  task automatic test_hold_start();
    int base, d0, r;
    bit ok = 1'b0;
    for (int i = 0; i < 8; i++) ram[i] = 8'(8'hE0 + i);
    tx_ready = 1'b1;
    base = q.size(); d0 = done_cnt;
    payload_len = 16'd2;
    start = 1'b1;
    tick();
    repeat (3) tick();
    payload_len = 16'd5;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (done) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok || busy !== 1'b0) begin failures++; $display("FAIL hold_first_done: ok=%0d busy=%b want 1,0", ok, busy); end
    tick();
    checks++;
    if (busy !== 1'b0 || tx_valid !== 1'b0) begin
      failures++; $display("FAIL hold_idle_gap: got busy=%b vld=%b want 0,0", busy, tx_valid);
    end
    tick();
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL hold_restart: got busy=%b want 1", busy); end
    start = 1'b0;
    r = frame_diff(base, 2);
    checks++;
    if (r != -1) begin failures++; $display("FAIL hold_first_frame: bad index %0d want -1", r); end
    wait_done(200, ok);
    r = frame_diff(base + 6, 5);
    checks++;
    if (!ok || r != -1) begin failures++; $display("FAIL hold_second_frame: ok=%0d idx=%0d want 1,-1", ok, r); end
    checks++;
    if (done_cnt - d0 != 2) begin failures++; $display("FAIL hold_done_count: got %0d want 2", done_cnt - d0); end
  endtask

  task automatic test_reset_mid();
    int base, d0, r;
    bit ok;
    for (int i = 0; i < 6; i++) ram[i] = 8'(8'h40 + 3 * i);
    tx_ready = 1'b1;
    base = q.size(); d0 = done_cnt;
    do_start(16'd4);
    for (int i = 0; i < 50 && q.size() - base < 4; i++) tick();
    tx_ready = 1'b0;
    for (int i = 0; i < 10 && !tx_valid; i++) tick();
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== ram[2]) begin
      failures++; $display("FAIL rst_mid_setup: got vld=%b data=%h want 1,%h", tx_valid, tx_data, ram[2]);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (tx_valid !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL rst_mid_outputs: got vld=%b busy=%b want 0,0", tx_valid, busy);
    end
    reset = 1'b0;
    tx_ready = 1'b1;
    repeat (5) tick();
    checks++;
    if (done_cnt != d0) begin failures++; $display("FAIL rst_mid_no_done: got %0d dones want 0", done_cnt - d0); end
    base = q.size();
    do_start(16'd4);
    wait_done(200, ok);
    r = frame_diff(base, 4);
    checks++;
    if (!ok || r != -1) begin failures++; $display("FAIL rst_mid_recover: ok=%0d idx=%0d want 1,-1", ok, r); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2048; i++) ram[i] = 8'h00;
    test_reset();
    test_basic();
    test_len0();
    test_stall();
    test_oversize();
    test_hold_start();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
